clk_sel_ctrl: RTL and testbench
===============================

// Module: clk_sel_ctrl
// PURPOSE
//   Sequencer for the select line of the 2:1 clock mux. Accepts switch
//   requests over a valid/ready handshake and gates the downstream clock
//   enable around every change of select. Switch order: quiesce (enable low),
//   change select, settle, re-enable, then minimum dwell before the next
//   request. Runs entirely on one reference clock.
// PARAMETERS
//   QUIESCE_CYC  4   cycles clk_en is low before sel changes (1..2^CNT_W-1)
//   SETTLE_CYC   8   cycles after the sel change before clk_en returns high (1..2^CNT_W-1)
//   DWELL_CYC    16  cycles after re-enable before the next request is accepted (1..2^CNT_W-1)
//   CNT_W        8   width of the shared down-counter
//   RST_SEL      0   value of sel while in reset
// PORTS
//   clk        in   1      reference clock, all logic on rising edge
//   rst_n      in   1      asynchronous reset, active low
//   req_valid  in   1      switch request present
//   req_sel    in   1      requested select value (0 = clk1, 1 = clk2)
//   req_ready  out  1      request accepted when req_valid & req_ready at a rising edge
//   sel        out  1      drives the mux select; registered
//   clk_en     out  1      downstream clock enable; registered
//   busy       out  1      high whenever state != IDLE
//   done       out  1      one-cycle pulse; request completed
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, sel=RST_SEL, clk_en=1, done=0, counter=0.
//     Then req_ready=1 and busy=0. Reset mid-sequence aborts immediately to these values.
//   States (2-bit): IDLE, QUIESCE, SETTLE, DWELL. req_ready = (state==IDLE).
//   Counter: load N-1 on entry to a timed state. Decrement each cycle. Leave the
//     state on the edge where the counter is 0.
//   Accept edge E0 (req_valid & req_ready):
//     - req_sel == sel: stay in IDLE, clk_en stays 1, done=1 for the cycle after E0.
//     - req_sel != sel: latch target=req_sel; state->QUIESCE; clk_en<=0 at E0.
//   QUIESCE -> SETTLE at edge E0+QUIESCE_CYC; sel<=target at that edge.
//   SETTLE -> DWELL at edge E0+QUIESCE_CYC+SETTLE_CYC; clk_en<=1 and done<=1
//     (one cycle) at that edge.
//   DWELL -> IDLE at edge E0+QUIESCE_CYC+SETTLE_CYC+DWELL_CYC.
//     The earliest next accept is at the following edge.
//   Outside IDLE, req_valid and req_sel are ignored. A requester holding valid
//     keeps its request pending and is accepted on the first edge with ready=1.
//     The value of req_sel sampled at that edge is the one used.
//   Invariants:
//     - sel changes only while clk_en=0, and only at the QUIESCE->SETTLE edge.
//     - clk_en is low for exactly QUIESCE_CYC+SETTLE_CYC cycles per real switch.
//     - done never pulses twice per accepted request.
//     - done is 0 in every cycle other than the completion cycle.
//   No arithmetic wrap: the counter never decrements below 0.
// TESTING (defaults Q=4, S=8, D=16)
//   1. Reset: hold rst_n=0 asynchronously mid-cycle.
//      -> sel=0, clk_en=1, req_ready=1, busy=0, done=0 without waiting for a clk edge.
//   2. sel=0, request req_sel=1 accepted at E0:
//      -> clk_en=0 after E0; sel=1 after E0+4; clk_en=1 and done=1 after E0+12
//         (done low after E0+13); req_ready=1 after E0+28.
//   3. sel=0, request req_sel=0:
//      -> done=1 for the single cycle after E0; clk_en stays 1; busy stays 0; sel stays 0.
//   4. req_valid held high through busy while req_sel toggles every cycle:
//      -> no second accept before E0+29; that accept uses the req_sel sampled at E0+29.
//   5. rst_n pulsed low after E0+6 (in SETTLE, sel already 1):
//      -> sel=0, clk_en=1, IDLE at once, no done pulse.
//      After release, a fresh req_sel=1 request completes with the timing of test 2.
//   6. Back-to-back 0->1->0 with req_valid held:
//      -> second accept E1=E0+29; sel=0 after E1+4.
//      -> Across the whole run, sel never changes while clk_en=1 (assertion).

Source files
------------

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: sequences the select line of a 2:1 clock mux.
// A switch request is accepted over a valid/ready handshake. Around every
// real change of select the downstream clock enable is dropped (quiesce),
// the select is changed, the new clock is allowed to settle, the enable is
// restored, and a minimum dwell time passes before the next request.
// A request for the select value already in use completes immediately
// with a single done pulse and no enable gap.
module clk_sel_ctrl #(
    parameter int   QUIESCE_CYC = 4,
    parameter int   SETTLE_CYC  = 8,
    parameter int   DWELL_CYC   = 16,
    parameter int   CNT_W       = 8,
    parameter logic RST_SEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic sel,
    output logic clk_en,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        SETTLE  = 2'd2,
        DWELL   = 2'd3
    } state_t;

    // The shared down-counter is loaded with N-1 on entry to a timed state,
    // so the state is left on the N-th edge after entry.
    localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD   = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             target;
    logic             target_nxt;
    logic             sel_nxt;
    logic             clk_en_nxt;
    logic             done_nxt;

    // State register: FSM state, counter, latched target and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            target <= RST_SEL;
            sel    <= RST_SEL;
            clk_en <= 1'b1;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            target <= target_nxt;
            sel    <= sel_nxt;
            clk_en <= clk_en_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic: handshake acceptance, timed phase sequencing and
    // the next values of the registered mux controls.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        sel_nxt    = sel;
        clk_en_nxt = clk_en;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_sel == sel) begin
                        done_nxt = 1'b1;
                    end else begin
                        target_nxt = req_sel;
                        state_nxt  = QUIESCE;
                        cnt_nxt    = QUIESCE_LOAD;
                        clk_en_nxt = 1'b0;
                    end
                end
            end
            QUIESCE: begin
                if (cnt == '0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                    sel_nxt   = target;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt  = DWELL;
                    cnt_nxt    = DWELL_LOAD;
                    clk_en_nxt = 1'b1;
                    done_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            DWELL: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode: handshake ready and busy follow the current state.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: directed bench for clk_sel_ctrl with a scoreboard of
// expected {sel, clk_en, req_ready, busy, done} vectors, one per cycle.
module tb_clk_sel_ctrl;

    localparam int Q = 4;
    localparam int S = 8;
    localparam int D = 16;
    localparam int SWITCH_LEN = Q + S + D + 1;

    typedef struct {
        string      tag;
        logic [4:0] vec;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic sel;
    logic clk_en;
    logic busy;
    logic done;

    sb_entry_t sb[$];
    int        n_checks;
    int        n_fail;
    logic      prev_sel;
    logic      prev_clk_en;

    clk_sel_ctrl #(
        .QUIESCE_CYC(Q),
        .SETTLE_CYC (S),
        .DWELL_CYC  (D),
        .CNT_W      (8),
        .RST_SEL    (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .sel      (sel),
        .clk_en   (clk_en),
        .busy     (busy),
        .done     (done)
    );

    // Reference clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the request inputs.
    task automatic applyStimulus(input logic v, input logic s);
        req_valid = v;
        req_sel   = s;
    endtask

    // Push one expected vector {sel, clk_en, req_ready, busy, done}.
    task automatic expectVec(input string tag, input logic [4:0] vec);
        sb_entry_t e;
        e.tag = tag;
        e.vec = vec;
        sb.push_back(e);
    endtask

    // Expected cycles of a real switch, sampled after edges E0 .. E0+Q+S+D.
    task automatic expectSwitch(input string tag, input logic from_sel, input logic to_sel);
        logic [4:0] v;
        for (int k = 0; k < SWITCH_LEN; k++) begin
            v[4] = (k >= Q) ? to_sel : from_sel;
            v[3] = (k >= Q + S);
            v[2] = (k >= Q + S + D);
            v[1] = (k < Q + S + D);
            v[0] = (k == Q + S);
            expectVec($sformatf("%s_k%0d", tag, k), v);
        end
    endtask

    // Expected cycles of a request for the select already in use.
    task automatic expectSame(input string tag, input logic s);
        expectVec($sformatf("%s_k0", tag), {s, 1'b1, 1'b1, 1'b0, 1'b1});
        expectVec($sformatf("%s_k1", tag), {s, 1'b1, 1'b1, 1'b0, 1'b0});
    endtask

    // Pop the oldest expected vector and compare against the DUT outputs.
    task automatic checkOutput();
        sb_entry_t  e;
        logic [4:0] obs;
        obs = {sel, clk_en, req_ready, busy, done};
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("[TB] FAIL scoreboard_empty observed=%b required=an expected entry", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                n_fail++;
                $error("[TB] FAIL %s {sel,clk_en,ready,busy,done} observed=%b required=%b",
                       e.tag, obs, e.vec);
            end
        end
    endtask

    // Advance one clock edge and check that sel only moves while clk_en is low.
    task automatic step();
        @(posedge clk);
        #1;
        n_checks++;
        assert ((sel === prev_sel) || (clk_en === 1'b0 && prev_clk_en === 1'b0)) else begin
            n_fail++;
            $error("[TB] FAIL sel_vs_clk_en observed sel %b->%b clk_en %b->%b required sel change only with clk_en=0",
                   prev_sel, sel, prev_clk_en, clk_en);
        end
        prev_sel    = sel;
        prev_clk_en = clk_en;
    endtask

    // Directed test sequence.
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b1;
        prev_sel    = 1'b0;
        prev_clk_en = 1'b1;
        applyStimulus(1'b0, 1'b0);

        // Asynchronous reset asserted mid-cycle, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        expectVec("reset_async", 5'b01100);
        checkOutput();
        #9 rst_n = 1'b1;
        prev_sel    = 1'b0;
        prev_clk_en = 1'b1;
        step();
        expectVec("idle_after_reset", 5'b01100);
        checkOutput();

        // Request for the select already in use: single done pulse only.
        $display("[TB] same-select request");
        applyStimulus(1'b1, 1'b0);
        expectSame("same0", 1'b0);
        step();
        checkOutput();
        applyStimulus(1'b0, 1'b0);
        step();
        checkOutput();

        // Full 0 -> 1 switch.
        $display("[TB] switch 0->1");
        applyStimulus(1'b1, 1'b1);
        expectSwitch("sw01", 1'b0, 1'b1);
        for (int k = 0; k < SWITCH_LEN; k++) begin
            step();
            checkOutput();
            if (k == 0) applyStimulus(1'b0, 1'b0);
        end

        // Valid held through busy with req_sel toggling; the value at the
        // first ready edge requests the current select.
        $display("[TB] held request with toggling select");
        applyStimulus(1'b1, 1'b0);
        expectSwitch("hold10", 1'b1, 1'b0);
        for (int k = 0; k < SWITCH_LEN; k++) begin
            step();
            checkOutput();
            if (k < SWITCH_LEN - 1) begin
                applyStimulus(1'b1, ~req_sel);
            end else begin
                applyStimulus(1'b1, 1'b0);
                expectSame("hold_same0", 1'b0);
            end
        end
        step();
        checkOutput();
        applyStimulus(1'b0, 1'b0);
        step();
        checkOutput();

        // Back-to-back 0 -> 1 -> 0 with valid held.
        $display("[TB] back-to-back 0->1->0");
        applyStimulus(1'b1, 1'b1);
        expectSwitch("b2b01", 1'b0, 1'b1);
        for (int k = 0; k < SWITCH_LEN; k++) begin
            step();
            checkOutput();
            if (k == SWITCH_LEN - 1) begin
                applyStimulus(1'b1, 1'b0);
                expectSwitch("b2b10", 1'b1, 1'b0);
            end
        end
        for (int k = 0; k < SWITCH_LEN; k++) begin
            step();
            checkOutput();
            if (k == 0) applyStimulus(1'b0, 1'b0);
        end

        // Reset during SETTLE aborts the switch with no done pulse.
        $display("[TB] reset during settle");
        applyStimulus(1'b1, 1'b1);
        expectSwitch("abort01", 1'b0, 1'b1);
        for (int k = 0; k <= 6; k++) begin
            step();
            checkOutput();
            if (k == 0) applyStimulus(1'b0, 1'b0);
        end
        sb.delete();
        #2 rst_n = 1'b0;
        #1;
        expectVec("reset_mid_settle", 5'b01100);
        checkOutput();
        prev_sel    = 1'b0;
        prev_clk_en = 1'b1;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expectVec($sformatf("idle_after_abort_%0d", k), 5'b01100);
            checkOutput();
        end

        // Fresh switch after the abort keeps the normal timing.
        $display("[TB] switch 0->1 after abort");
        applyStimulus(1'b1, 1'b1);
        expectSwitch("post01", 1'b0, 1'b1);
        for (int k = 0; k < SWITCH_LEN; k++) begin
            step();
            checkOutput();
            if (k == 0) applyStimulus(1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
